// File: rtl/check.sv
// Program-entry and RAW-hazard front end for the 8-bit HDU-RISC pipeline:
// button-captured instruction memory plus a NOP-inserting issue scheduler.
module check (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   input_val,
    input  logic         but_inp,
    output logic [63:0]  instrMemBits,
    output logic [103:0] hazardMemBits
);

    localparam int unsigned NUM_ENTRIES = 8;
    localparam int unsigned NUM_SLOTS   = 13;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SCAN
    } state_t;

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       prev_q, prev_d;
    logic [7:0] entry_q [NUM_ENTRIES];
    logic [7:0] entry_d [NUM_ENTRIES];
    logic [3:0] wp_q, wp_d;
    state_t     state_q, state_d;
    logic [7:0] slot_q [NUM_SLOTS];
    logic [7:0] slot_d [NUM_SLOTS];
    logic [3:0] slot_ptr_q, slot_ptr_d;
    logic [3:0] idx_q, idx_d;
    logic [2:0] last1_q, last1_d;
    logic [2:0] last2_q, last2_d;
    logic [7:0] cur;
    logic       capture;

    // Destination encoded as {valid, reg}; r0 and STORE never produce a result.
    function automatic logic [2:0] dest_of(input logic [7:0] ins);
        logic [2:0] d;
        d = 3'b000;
        if (ins[7:6] != 2'b10 && ins[5:4] != 2'b00) begin
            d = {1'b1, ins[5:4]};
        end
        return d;
    endfunction

    function automatic logic reads_reg(input logic [7:0] ins, input logic [2:0] dst);
        logic hit;
        hit = 1'b0;
        if (dst[2]) begin
            hit = (ins[3:2] == dst[1:0]);
            if (!ins[7]) begin
                hit = hit | (ins[1:0] == dst[1:0]);
            end
            if (ins[7:6] == 2'b10) begin
                hit = hit | (ins[5:4] == dst[1:0]);
            end
        end
        return hit;
    endfunction

    always_comb begin
        sync1_d    = but_inp;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        entry_d    = entry_q;
        wp_d       = wp_q;
        state_d    = state_q;
        slot_d     = slot_q;
        slot_ptr_d = slot_ptr_q;
        idx_d      = idx_q;
        last1_d    = last1_q;
        last2_d    = last2_q;
        cur        = entry_q[idx_q[2:0]];
        capture    = (sync2_q != prev_q) && (wp_q != 4'd8);

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            CLEAR: begin
                for (int k = 0; k < NUM_SLOTS; k++) begin
                    slot_d[k] = 8'h00;
                end
                slot_ptr_d = 4'd0;
                idx_d      = 4'd0;
                last1_d    = 3'b000;
                last2_d    = 3'b000;
                state_d    = SCAN;
            end
            SCAN: begin
                if (idx_q == wp_q || slot_ptr_q == 4'd13) begin
                    state_d = IDLE;
                end else begin
                    // A hazard against either of the last two slots costs one bubble per cycle.
                    if (reads_reg(cur, last1_q) || reads_reg(cur, last2_q)) begin
                        slot_d[slot_ptr_q] = 8'h00;
                        last1_d            = 3'b000;
                    end else begin
                        slot_d[slot_ptr_q] = cur;
                        last1_d            = dest_of(cur);
                        idx_d              = idx_q + 4'd1;
                    end
                    last2_d    = last1_q;
                    slot_ptr_d = slot_ptr_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture) begin
            entry_d[wp_q[2:0]] = input_val;
            wp_d               = wp_q + 4'd1;
            state_d            = CLEAR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            wp_q       <= 4'd0;
            state_q    <= IDLE;
            slot_ptr_q <= 4'd0;
            idx_q      <= 4'd0;
            last1_q    <= 3'b000;
            last2_q    <= 3'b000;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entry_q[i] <= 8'h00;
            end
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slot_q[k] <= 8'h00;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            wp_q       <= wp_d;
            state_q    <= state_d;
            slot_ptr_q <= slot_ptr_d;
            idx_q      <= idx_d;
            last1_q    <= last1_d;
            last2_q    <= last2_d;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entry_q[i] <= entry_d[i];
            end
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    always_comb begin
        instrMemBits  = '0;
        hazardMemBits = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            instrMemBits[8*i +: 8] = entry_q[i];
        end
        for (int k = 0; k < NUM_SLOTS; k++) begin
            hazardMemBits[8*k +: 8] = slot_q[k];
        end
    end

endmodule

// File: tb/tb_check.sv
// Bench for check: table vectors, hand-written corner sequences and randomized
// programs compared against an issue-time scoreboard model.
module tb_check;

    logic         clk;
    logic         rst;
    logic [7:0]   input_val;
    logic         but_inp;
    logic [63:0]  instrMemBits;
    logic [103:0] hazardMemBits;

    int checks;
    int errors;

    typedef struct packed {
        logic [3:0]   n;
        logic [63:0]  ins;
        logic [63:0]  exp_instr;
        logic [103:0] exp_sched;
    } vec_t;

    vec_t vecs [5];

    check dut (
        .clk           (clk),
        .rst           (rst),
        .input_val     (input_val),
        .but_inp       (but_inp),
        .instrMemBits  (instrMemBits),
        .hazardMemBits (hazardMemBits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [103:0] act, input logic [103:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst     = 1'b1;
        but_inp = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One button toggle; waits until the capture and the CLEAR that follows it are done.
    task automatic applyStimulus(input logic [7:0] val);
        @(negedge clk);
        input_val = val;
        but_inp   = ~but_inp;
        repeat (4) @(negedge clk);
    endtask

    // Reference: each instruction issues at the earliest slot that is after the previous
    // issue and at least 3 after the latest writer of every register it reads.
    function automatic logic [103:0] model_sched(input logic [63:0] ins, input int n);
        logic [103:0] s;
        int ready [4];
        int nxt;
        int t;
        logic [7:0] b;
        s   = '0;
        nxt = 0;
        for (int r = 0; r < 4; r++) ready[r] = 0;
        for (int i = 0; i < n; i++) begin
            b = ins[8*i +: 8];
            t = nxt;
            if (b[3:2] != 2'b00 && ready[b[3:2]] > t) t = ready[b[3:2]];
            if (b[7] == 1'b0 && b[1:0] != 2'b00 && ready[b[1:0]] > t) t = ready[b[1:0]];
            if (b[7:6] == 2'b10 && b[5:4] != 2'b00 && ready[b[5:4]] > t) t = ready[b[5:4]];
            if (t > 12) break;
            s[8*t +: 8] = b;
            nxt = t + 1;
            if (b[7:6] != 2'b10 && b[5:4] != 2'b00) ready[b[5:4]] = t + 3;
        end
        return s;
    endfunction

    initial begin
        logic [63:0] ins_l;
        logic [63:0] exp_i;
        int n;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        but_inp   = 1'b1;
        input_val = 8'h00;

        vecs[0] = '{n: 4'd8, ins: 64'h5FCBBB5E9E59DCCA, exp_instr: 64'h5FCBBB5E9E59DCCA,
                    exp_sched: 104'h00_5F_CB_BB_5E_9E_00_00_59_00_00_DC_CA};
        vecs[1] = '{n: 4'd2, ins: 64'h491B, exp_instr: 64'h491B,
                    exp_sched: 104'h49_00_00_1B};
        vecs[2] = '{n: 4'd3, ins: 64'h442A1B, exp_instr: 64'h442A1B,
                    exp_sched: 104'h44_00_2A_1B};
        vecs[3] = '{n: 4'd2, ins: 64'h400F, exp_instr: 64'h400F,
                    exp_sched: 104'h400F};
        vecs[4] = '{n: 4'd8, ins: 64'h1515151515151515, exp_instr: 64'h1515151515151515,
                    exp_sched: 104'h15_00_00_15_00_00_15_00_00_15_00_00_15};

        applyReset();
        checkOutput("reset_instr", instrMemBits, 104'h0);
        checkOutput("reset_sched", hazardMemBits, 104'h0);

        for (int v = 0; v < 5; v++) begin
            applyReset();
            ins_l = vecs[v].ins;
            for (int i = 0; i < int'(vecs[v].n); i++) begin
                applyStimulus(ins_l[8*i +: 8]);
            end
            repeat (14) @(negedge clk);
            checkOutput($sformatf("vec%0d_instr", v), instrMemBits, vecs[v].exp_instr);
            checkOutput($sformatf("vec%0d_sched", v), hazardMemBits, vecs[v].exp_sched);
        end

        // Ninth toggle after a full memory must be ignored entirely.
        applyStimulus(8'hFF);
        repeat (14) @(negedge clk);
        checkOutput("full_instr", instrMemBits, vecs[4].exp_instr);
        checkOutput("full_sched", hazardMemBits, vecs[4].exp_sched);

        // Reset in the middle of a scan, then a fresh capture lands in entry 0.
        applyReset();
        ins_l = vecs[2].ins;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(ins_l[8*i +: 8]);
        end
        checkOutput("midscan_instr", instrMemBits, 104'h442A1B);
        @(negedge clk);
        rst     = 1'b1;
        but_inp = 1'b1;
        @(negedge clk);
        checkOutput("midrst_instr", instrMemBits, 104'h0);
        checkOutput("midrst_sched", hazardMemBits, 104'h0);
        rst = 1'b0;
        applyStimulus(8'hA5);
        checkOutput("after_rst_instr", instrMemBits, 104'hA5);
        repeat (14) @(negedge clk);
        checkOutput("after_rst_sched", hazardMemBits, 104'hA5);

        for (int r = 0; r < 24; r++) begin
            applyReset();
            n     = int'($urandom_range(1, 8));
            ins_l = '0;
            exp_i = '0;
            for (int i = 0; i < n; i++) begin
                ins_l[8*i +: 8] = 8'($urandom);
                exp_i[8*i +: 8] = ins_l[8*i +: 8];
                applyStimulus(ins_l[8*i +: 8]);
            end
            repeat (14) @(negedge clk);
            checkOutput($sformatf("rand%0d_instr", r), instrMemBits, exp_i);
            checkOutput($sformatf("rand%0d_sched", r), hazardMemBits, model_sched(ins_l, n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
